// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer.
//   state_t     : frame alignment state (HUNT / LOCKED)
//   NUM_CH      : number of TDM channels (slots per frame)
//   SLOT_W      : width of the slot index
//   even_parity : returns the bit that makes the word's total parity even
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    // Callers zero-extend their data to 64 bits; the extra zeros do not change parity.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame alignment tracker for the TDM demultiplexer.
// Owns the HUNT/LOCKED state, the slot counter and the missing-fsync counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   beat       : a sample is present this cycle (din_valid)
//   fsync      : frame sync, only meaningful when beat is high
//   slot       : channel the current beat is steered to (combinational)
//   wr_en      : current beat must be written to channel 'slot' (combinational)
//   locked     : registered, high while in LOCKED
//   sync_err   : combinational, misplaced or missing fsync on this beat
module tdm_sync_fsm
    import tdm_pkg::*;
#(
    parameter int MISS_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat,
    input  logic              fsync,
    output logic [SLOT_W-1:0] slot,
    output logic              wr_en,
    output logic              locked,
    output logic              sync_err
);

    localparam logic [2:0] LIMIT = 3'(MISS_LIMIT);

    state_t            state_reg, state_next;
    logic [SLOT_W-1:0] slot_reg, slot_next;
    logic [2:0]        miss_reg, miss_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            slot_reg  <= '0;
            miss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
            miss_reg  <= miss_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        miss_next  = miss_reg;
        slot       = slot_reg;
        wr_en      = 1'b0;
        sync_err   = 1'b0;
        if (beat) begin
            case (state_reg)
                HUNT: begin
                    if (fsync) begin
                        wr_en      = 1'b1;
                        slot       = '0;
                        slot_next  = SLOT_W'(1);
                        miss_next  = '0;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    wr_en     = 1'b1;
                    slot_next = slot_reg + SLOT_W'(1);
                    if (fsync && slot_reg != '0) begin
                        // Early fsync: realign so this sample becomes slot 0.
                        slot      = '0;
                        slot_next = SLOT_W'(1);
                        sync_err  = 1'b1;
                        miss_next = '0;
                    end else if (fsync) begin
                        miss_next = '0;
                    end else if (slot_reg == '0) begin
                        // Expected fsync is missing; the sample is still captured.
                        sync_err = 1'b1;
                        if (miss_reg + 3'd1 == LIMIT) begin
                            state_next = HUNT;
                            miss_next  = '0;
                            slot_next  = '0;
                        end else begin
                            miss_next = miss_reg + 3'd1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign locked = (state_reg == LOCKED);

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel time-division demultiplexer.
// Steers each valid sample on the shared bus into one of four channel
// registers, aligned to the frame by tdm_sync_fsm. Outputs are one register
// stage behind the input beat.
// Optional feature: define TDM_PARITY_EN to widen din by one even-parity bit
// (MSB); beats with bad parity are not written but still advance the slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : sample (W bits, or W+1 with TDM_PARITY_EN)
//   din_valid  : sample present this cycle
//   fsync      : marks slot 0, qualified by din_valid
//   ch_data    : channel registers, channel n at [n*W +: W]
//   ch_valid   : per-channel one-cycle update pulse
//   frame_done : pulse when slot 3 is written while locked
//   locked     : frame alignment held
//   sync_err   : pulse on misplaced or missing fsync
//   par_err    : pulse on parity failure (constant 0 without TDM_PARITY_EN)
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W          = 8,
    parameter int MISS_LIMIT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef TDM_PARITY_EN
    input  logic [W:0]          din,
`else
    input  logic [W-1:0]        din,
`endif
    input  logic                din_valid,
    input  logic                fsync,
    output logic [NUM_CH*W-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_valid,
    output logic                frame_done,
    output logic                locked,
    output logic                sync_err,
    output logic                par_err
);

    logic [SLOT_W-1:0] slot;
    logic              wr_en;
    logic              sync_err_comb;
    logic              par_ok;
    logic              wr;

    logic [W-1:0]      ch_reg [NUM_CH];
    logic [NUM_CH-1:0] ch_valid_reg;
    logic              frame_done_reg;
    logic              sync_err_reg;

    tdm_sync_fsm #(
        .MISS_LIMIT (MISS_LIMIT)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat     (din_valid),
        .fsync    (fsync),
        .slot     (slot),
        .wr_en    (wr_en),
        .locked   (locked),
        .sync_err (sync_err_comb)
    );

`ifdef TDM_PARITY_EN
    logic par_err_reg;

    assign par_ok = (even_parity(64'(din[W-1:0])) == din[W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_reg <= 1'b0;
        end else begin
            par_err_reg <= din_valid && !par_ok;
        end
    end

    assign par_err = par_err_reg;
`else
    assign par_ok  = 1'b1;
    assign par_err = 1'b0;
`endif

    // A bad-parity beat still advances the FSM, it just does not land.
    assign wr = wr_en && par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_reg[i] <= '0;
            end
            ch_valid_reg   <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && slot == SLOT_W'(i)) begin
                    ch_reg[i] <= din[W-1:0];
                end
                ch_valid_reg[i] <= wr && (slot == SLOT_W'(i));
            end
            // Only LOCKED can address slot 3, so no explicit state term is needed.
            frame_done_reg <= wr && (slot == SLOT_W'(NUM_CH - 1));
            sync_err_reg   <= sync_err_comb;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_data[gi*W +: W] = ch_reg[gi];
    end

    assign ch_valid   = ch_valid_reg;
    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (W=8, MISS_LIMIT=2).
// A frame-level model predicts every output each cycle; directed literal
// checks pin the model on the key scenarios.
module tb_tdm_demux4;

    localparam int W  = 8;
    localparam int ML = 2;

    logic          clk;
    logic          rst_n;
`ifdef TDM_PARITY_EN
    logic [W:0]    din;
`else
    logic [W-1:0]  din;
`endif
    logic          din_valid;
    logic          fsync;
    logic [4*W-1:0] ch_data;
    logic [3:0]    ch_valid;
    logic          frame_done;
    logic          locked;
    logic          sync_err;
    logic          par_err;

    int tests = 0;
    int fails = 0;

    tdm_demux4 #(.W(W), .MISS_LIMIT(ML)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .fsync      (fsync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err),
        .par_err    (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_ch [4];
    bit         m_locked;
    int         m_next;      // slot the next sample is expected to occupy
    int         m_miss;
    logic [3:0] m_valid;
    bit         m_fd;
    bit         m_se;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
        m_locked = 0; m_next = 0; m_miss = 0;
        m_valid = 4'b0; m_fd = 0; m_se = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                int tgt;
                m_valid = 4'b0; m_fd = 0; m_se = 0;
                if (din_valid) begin
                    if (!m_locked) begin
                        if (fsync) begin
                            m_ch[0] = din[7:0]; m_valid = 4'b0001;
                            m_locked = 1; m_next = 1; m_miss = 0;
                        end
                    end else begin
                        tgt = m_next;
                        if (fsync) begin
                            if (m_next != 0) m_se = 1;
                            tgt = 0;
                            m_miss = 0;
                        end else if (m_next == 0) begin
                            m_se = 1;
                            m_miss = m_miss + 1;
                        end
                        m_ch[tgt] = din[7:0];
                        m_valid = 4'(1 << tgt);
                        m_fd = (tgt == 3);
                        m_next = (tgt + 1) % 4;
                        if (m_miss == ML) begin
                            m_locked = 0; m_miss = 0; m_next = 0;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit run_cmp = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                check("m_ch_data", ch_data, {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
                check("m_ch_valid", ch_valid, m_valid);
                check("m_frame_done", frame_done, m_fd);
                check("m_locked", locked, m_locked);
                check("m_sync_err", sync_err, m_se);
                check("m_par_err", par_err, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input bit v, input bit fs, input logic [7:0] d);
        din_valid = v;
        fsync     = fs;
`ifdef TDM_PARITY_EN
        din = {^d, d};
`else
        din = d;
`endif
        @(posedge clk); #1;
        din_valid = 1'b0;
        fsync     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; fsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_cmp = 1;
        check("rst_ch_data", ch_data, 32'h0);
        check("rst_locked", locked, 1'b0);
        rst_n = 1'b1;

        // Valid beats without fsync stay unlocked and silent.
        for (int i = 0; i < 3; i++) begin
            beat(1, 0, 8'h10 + 8'(i));
            check("hunt_locked", locked, 1'b0);
            check("hunt_ch_valid", ch_valid, 4'b0000);
        end

        // First aligned frame.
        beat(1, 1, 8'hA1);
        check("f1_v0", ch_valid, 4'b0001);
        check("f1_locked", locked, 1'b1);
        beat(1, 0, 8'hB2); check("f1_v1", ch_valid, 4'b0010);
        beat(1, 0, 8'hC3); check("f1_v2", ch_valid, 4'b0100);
        beat(1, 0, 8'hD4);
        check("f1_v3", ch_valid, 4'b1000);
        check("f1_fd", frame_done, 1'b1);
        check("f1_data", ch_data, 32'hD4C3B2A1);

        // Early fsync on the third beat realigns.
        beat(1, 1, 8'h11);
        check("rs_se0", sync_err, 1'b0);
        beat(1, 0, 8'h22);
        beat(1, 1, 8'h33);
        check("rs_se", sync_err, 1'b1);
        check("rs_v", ch_valid, 4'b0001);
        check("rs_ch0", ch_data[7:0], 8'h33);
        beat(1, 0, 8'h44);
        check("rs_next_v", ch_valid, 4'b0010);
        check("rs_ch1", ch_data[15:8], 8'h44);
        beat(1, 0, 8'h55);
        beat(1, 0, 8'h66);
        check("rs_fd", frame_done, 1'b1);

        // Two frames with missing fsync drop lock.
        beat(1, 0, 8'h77);
        check("miss1_se", sync_err, 1'b1);
        check("miss1_locked", locked, 1'b1);
        check("miss1_v", ch_valid, 4'b0001);
        beat(1, 0, 8'h78); beat(1, 0, 8'h79); beat(1, 0, 8'h7A);
        beat(1, 0, 8'h88);
        check("miss2_se", sync_err, 1'b1);
        check("miss2_locked", locked, 1'b0);
        check("miss2_data", ch_data, 32'h7A797888);
        beat(1, 0, 8'h99);
        check("miss_hunt_v", ch_valid, 4'b0000);

        // Gaps inside a frame do not disturb alignment.
        beat(1, 1, 8'h01);
        beat(0, 0, 8'hEE);
        check("gap_v", ch_valid, 4'b0000);
        beat(1, 0, 8'h02);
        beat(0, 1, 8'hEE);
        beat(0, 0, 8'hEE);
        beat(1, 0, 8'h03);
        beat(1, 0, 8'h04);
        check("gap_fd", frame_done, 1'b1);
        check("gap_data", ch_data, 32'h04030201);

        // Asynchronous reset mid-frame.
        beat(1, 1, 8'hAA);
        beat(1, 0, 8'hBB);
        rst_n = 1'b0;
        #2;
        check("arst_data", ch_data, 32'h0);
        check("arst_locked", locked, 1'b0);
        check("arst_valid", ch_valid, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(1, 0, 8'hCC);
        check("post_rst_v", ch_valid, 4'b0000);
        check("post_rst_locked", locked, 1'b0);
        beat(1, 1, 8'hDD);
        check("relock", locked, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        run_cmp = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
